// File: rtl/gas_bp_2bc.sv
// gas_bp_2bc -- global-history branch predictor with CNT_BIT-wide saturating
// counters, a combinational fetch-side lookup port and an execute-side update
// port. The global history register (GHR) is speculative. Each lookup shifts
// in its own prediction, and a mispredicted update rebuilds the GHR from the
// snapshot that travelled with the branch.
//
// Optional feature: define BP_GSHARE_EN to hash the row index as
// GHR ^ pc[GHT_BIT+1:2] (gshare). Without it the row is the raw GHR (GAs).
// The same hash is used for lookup and for update.
//
// Ports:
//   clock, reset      single clock; synchronous active-high reset
//   enable            gates every GHR/PHT write; outputs stay driven
//   pred_valid/pred_pc             fetch lookup (consumed this cycle)
//   prediction_out/pred_ghr_out    predicted direction and GHR snapshot
//   upd_valid/upd_pc/upd_ghr/upd_taken/upd_mispredict  resolved-branch training
//   ghr_out           current speculative GHR
module gas_bp_2bc #(
  parameter int GHT_BIT    = 4,
  parameter int PHT_PC_BIT = 2,
  parameter int CNT_BIT    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               pred_valid,
  input  logic [31:0]        pred_pc,
  output logic               prediction_out,
  output logic [GHT_BIT-1:0] pred_ghr_out,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic [GHT_BIT-1:0] upd_ghr,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic [GHT_BIT-1:0] ghr_out
);

  localparam int IDX_W   = GHT_BIT + PHT_PC_BIT;
  localparam int ENTRIES = 2 ** IDX_W;
  // Weakly not-taken: MSB clear, all lower bits set (0 when CNT_BIT = 1).
  localparam logic [CNT_BIT-1:0] CNT_INIT = CNT_BIT'((2 ** (CNT_BIT - 1)) - 1);

  function automatic logic [CNT_BIT-1:0] sat_step(input logic [CNT_BIT-1:0] cnt,
                                                  input logic              up);
    if (up) return (&cnt) ? cnt : cnt + CNT_BIT'(1);
    else    return (|cnt) ? cnt - CNT_BIT'(1) : cnt;
  endfunction

  logic [GHT_BIT-1:0] ghr_q, ghr_d;
  logic [CNT_BIT-1:0] pht_q [ENTRIES];
  logic [CNT_BIT-1:0] cnt_d;
  logic               pht_we;
  logic [GHT_BIT-1:0] pred_hash, upd_hash;
  logic [IDX_W-1:0]   pred_idx, upd_idx;
  logic               unused_pc;

  // Only a few PC bits index the table; the rest are deliberately ignored.
  assign unused_pc = ^{pred_pc, upd_pc};

`ifdef BP_GSHARE_EN
  assign pred_hash = pred_pc[GHT_BIT+1:2];
  assign upd_hash  = upd_pc[GHT_BIT+1:2];
`else
  assign pred_hash = '0;
  assign upd_hash  = '0;
`endif

  always_comb begin
    pred_idx       = {ghr_q ^ pred_hash, pred_pc[PHT_PC_BIT+1:2]};
    upd_idx        = {upd_ghr ^ upd_hash, upd_pc[PHT_PC_BIT+1:2]};
    // Lookup reads the registered table, so a same-cycle update to the
    // same entry is not bypassed.
    prediction_out = pht_q[pred_idx][CNT_BIT-1];
    pred_ghr_out   = ghr_q;
    ghr_out        = ghr_q;
    cnt_d          = sat_step(pht_q[upd_idx], upd_taken);
    pht_we         = enable & upd_valid;

    ghr_d = ghr_q;
    if (enable) begin
      // Recovery wins: fetch is being flushed, so its shift is dropped.
      if (upd_valid && upd_mispredict) ghr_d = {upd_ghr[GHT_BIT-2:0], upd_taken};
      else if (pred_valid)             ghr_d = {ghr_q[GHT_BIT-2:0], prediction_out};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CNT_INIT;
    end else begin
      ghr_q <= ghr_d;
      if (pht_we) pht_q[upd_idx] <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gas_bp_2bc.sv
// Testbench for gas_bp_2bc: directed walk through the predictor's key
// behaviours followed by a randomized phase, all compared against a
// behavioural model of the counters and history kept as integer arrays.
module tb_gas_bp_2bc;

  localparam int GHT_BIT    = 4;
  localparam int PHT_PC_BIT = 2;
  localparam int CNT_BIT    = 2;
  localparam int ROWS       = 2 ** GHT_BIT;
  localparam int COLS       = 2 ** PHT_PC_BIT;
  localparam int HALF       = 2 ** (CNT_BIT - 1);
  localparam int CMAX       = 2 * HALF - 1;

  logic               clock = 1'b0;
  logic               reset, enable, pred_valid, upd_valid, upd_taken, upd_mispredict;
  logic [31:0]        pred_pc, upd_pc;
  logic [GHT_BIT-1:0] upd_ghr;
  logic               prediction_out;
  logic [GHT_BIT-1:0] pred_ghr_out, ghr_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt [ROWS][COLS];
  int m_ghr;
  bit m_valid = 1'b0;

  gas_bp_2bc #(.GHT_BIT(GHT_BIT), .PHT_PC_BIT(PHT_PC_BIT), .CNT_BIT(CNT_BIT)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .prediction_out(prediction_out), .pred_ghr_out(pred_ghr_out),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ghr_out(ghr_out)
  );

  always #5 clock = ~clock;

  function automatic int m_col(input logic [31:0] pc);
    return int'((pc >> 2) % COLS);
  endfunction

  function automatic int m_row(input int g, input logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return g ^ int'((pc >> 2) % ROWS);
`else
    return g;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic pv, input logic [31:0] ppc,
                       input logic uv, input logic [31:0] upc, input logic [GHT_BIT-1:0] ughr,
                       input logic ut, input logic um);
    reset = 1'b0; enable = en; pred_valid = pv; pred_pc = ppc;
    upd_valid = uv; upd_pc = upc; upd_ghr = ughr; upd_taken = ut; upd_mispredict = um;
  endtask

  // Check outputs against the model mid-cycle, clock once, advance the model.
  task automatic tick(input string tag);
    int p, r, c;
    #1;
    p = 0;
    if (m_valid) begin
      r = m_row(m_ghr, pred_pc);
      c = m_col(pred_pc);
      p = (m_cnt[r][c] >= HALF) ? 1 : 0;
      chk({tag, "_pred"}, 32'(prediction_out), 32'(p));
      chk({tag, "_pghr"}, 32'(pred_ghr_out), 32'(m_ghr));
      chk({tag, "_ghr"},  32'(ghr_out), 32'(m_ghr));
    end
    @(posedge clock);
    if (reset) begin
      m_ghr = 0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) m_cnt[i][j] = HALF - 1;
      m_valid = 1'b1;
    end else if (enable && m_valid) begin
      if (upd_valid) begin
        r = m_row(int'(upd_ghr), upd_pc);
        c = m_col(upd_pc);
        if (upd_taken && m_cnt[r][c] < CMAX) m_cnt[r][c]++;
        else if (!upd_taken && m_cnt[r][c] > 0) m_cnt[r][c]--;
      end
      if (upd_valid && upd_mispredict) m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) % ROWS;
      else if (pred_valid)             m_ghr = ((m_ghr << 1) | p) % ROWS;
    end
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick("rst");
    #1;
    chk("reset_pred", 32'(prediction_out), 0);
    chk("reset_pghr", 32'(pred_ghr_out), 0);
    chk("reset_ghr",  32'(ghr_out), 0);

    // First lookup after reset: weakly not-taken counter, GHR shifts in 0.
    drive(1, 1, 32'h0, 0, 0, 0, 0, 0);
    tick("look0");

    // Mispredict taken at pc 0: counter[0][0] 01->10, GHR recovers to 0001.
    drive(1, 0, 32'h0, 1, 32'h0, 4'b0000, 1, 1);
    tick("rec1");
    chk("rec1_ghr_const", 32'(ghr_out), 32'h1);
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
    #1 chk("row1_pred_const", 32'(prediction_out), 0);
    tick("row1");

    // Steer GHR back to 0 and confirm counter[0][0] now predicts taken.
    drive(1, 0, 32'h0, 1, 32'h8, 4'b1000, 0, 1);
    tick("to0");
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
    #1 chk("c00_taken_const", 32'(prediction_out), 1);
    tick("c00");

    // Saturate counter[0][1] upward, then walk it down and saturate at 0.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h4, 1, 32'h4, 4'b0000, 1, 0);
      tick("sat_up");
    end
    drive(1, 0, 32'h4, 1, 32'h4, 4'b0000, 0, 0);
    tick("dn1");
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
    #1 chk("c01_10_const", 32'(prediction_out), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h4, 1, 32'h4, 4'b0000, 0, 0);
      tick("sat_dn");
    end
    drive(1, 0, 32'h4, 1, 32'h4, 4'b0000, 1, 0);
    tick("up_from0");
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
    #1 chk("c01_01_const", 32'(prediction_out), 0);
    tick("c01");

    // Recovery overrides a same-cycle lookup shift.
    drive(1, 1, 32'h4, 1, 32'h10, 4'b1010, 1, 1);
    tick("prio");
    chk("prio_ghr_const", 32'(ghr_out), 32'h5);

    // enable low: nothing changes, outputs still driven.
    drive(0, 1, 32'h4, 1, 32'h4, 4'b0000, 1, 1);
    tick("en0");
    chk("en0_ghr_const", 32'(ghr_out), 32'h5);
    drive(0, 1, 32'h4, 1, 32'h4, 4'b0000, 1, 0);
    tick("en0b");
    drive(1, 0, 32'h0, 1, 32'h8, 4'b1000, 0, 1);
    tick("to0b");
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
    #1 chk("en0_cnt_const", 32'(prediction_out), 0);
    tick("en0c");

    // Train entry [0][3] taken, set GHR = 0011, look up pc 0xC.
    for (int i = 0; i < 2; i++) begin
`ifdef BP_GSHARE_EN
      drive(1, 0, 32'h0, 1, 32'hC, 4'b0011, 1, 0);
`else
      drive(1, 0, 32'h0, 1, 32'hC, 4'b0000, 1, 0);
`endif
      tick("trn03");
    end
    drive(1, 0, 32'h0, 1, 32'h8, 4'b0001, 1, 1);
    tick("to3");
    drive(1, 1, 32'hC, 0, 0, 0, 0, 0);
    #1;
    chk("hash_pghr_const", 32'(pred_ghr_out), 32'h3);
`ifdef BP_GSHARE_EN
    chk("hash_pred_const", 32'(prediction_out), 1);
`else
    chk("hash_pred_const", 32'(prediction_out), 0);
`endif
    tick("hash");

    // Randomized phase against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom), $urandom,
            1'($urandom), $urandom, GHT_BIT'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gas_bp_2bc.md
# gas_bp_2bc

Parametrised successor to the 1-bit GAs branch predictor: a global-history predictor with N-bit saturating counters, decoupled predict (fetch) and update (execute/retire) ports, and speculative history with mispredict recovery. It sits in the fetch stage and is trained from the branch-resolution stage. Each prediction returns a history snapshot that travels with the branch and comes back on update.

## Interface
Parameters:
- `GHT_BIT`, 4, global history length; PHT row count is 2**GHT_BIT.
- `PHT_PC_BIT`, 2, PC bits selecting the column; column count is 2**PHT_PC_BIT.
- `CNT_BIT`, 2, saturating counter width (≥1; CNT_BIT=1 reproduces the 1-bit predictor).

Ports:
- `clock`  in  1  single clock, all state on posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  gates every state write; outputs remain driven when low.
- `pred_valid`  in  1  a fetch-side lookup is consumed this cycle.
- `pred_pc`  in  32  lookup PC.
- `prediction_out`  out  1  predicted direction, 1 = taken.
- `pred_ghr_out`  out  GHT_BIT  speculative GHR used for this lookup (snapshot).
- `upd_valid`  in  1  a resolved branch trains the table this cycle.
- `upd_pc`  in  32  resolved branch PC.
- `upd_ghr`  in  GHT_BIT  snapshot returned from prediction time.
- `upd_taken`  in  1  actual direction.
- `upd_mispredict`  in  1  resolution disagreed with prediction; qualified by upd_valid.
- `ghr_out`  out  GHT_BIT  current speculative GHR (debug/visibility).

## Operation
- State: speculative GHR (GHT_BIT bits), PHT of 2**GHT_BIT × 2**PHT_PC_BIT counters of CNT_BIT bits.
- Column index: pc[PHT_PC_BIT+1:2] (word-aligned). Row index: GHR (lookup) or upd_ghr (update), see Configuration.
- Lookup is combinational: prediction_out = MSB of PHT[row(GHR, pred_pc)][col(pred_pc)]; pred_ghr_out = GHR.
- On pred_valid & enable: GHR ← {GHR[GHT_BIT-2:0], prediction_out}.
- On upd_valid & enable: counter at [row(upd_ghr, upd_pc)][col(upd_pc)] increments if upd_taken (saturate at all-ones), decrements otherwise (saturate at 0).
- On upd_valid & upd_mispredict & enable: GHR ← {upd_ghr[GHT_BIT-2:0], upd_taken} (recovery).
- Priority: recovery overrides the pred_valid shift in the same cycle; the concurrent lookup's shift is discarded (fetch is flushed anyway).
- Same-cycle lookup and update of one entry: lookup sees the pre-update value (no bypass).
- enable low: no GHR or PHT change; lookups still produce outputs.

## Timing
- Reset (sync): GHR = 0; every counter = 2**(CNT_BIT-1)-1 (weakly not-taken; 0 when CNT_BIT=1). Hence prediction_out = 0, pred_ghr_out = 0, ghr_out = 0 the cycle after reset.
- Reset mid-operation overrides pred_valid/upd_valid in the same cycle; all in-flight snapshots become meaningless.
- Prediction latency 0 cycles (same-cycle combinational); GHR and counter updates visible the cycle after the edge.
- No handshake back-pressure: one lookup and one update accepted every cycle.

## Configuration
- `BP_GSHARE_EN` defined: row = GHR ^ pc[GHT_BIT+1:2] (gshare hashing), applied identically for lookup and update.
- Not defined: row = GHR unmodified (GAs); pred_pc affects only the column.

## Test plan
- Reset, then lookup pc=0 -> prediction_out=0, pred_ghr_out=0000, counter[0][0]=01.
- upd_valid, pc=0, upd_ghr=0000, upd_taken=1, upd_mispredict=1 -> counter[0][0]=10, ghr_out=0001 next cycle; lookup pc=0 then reads row 0001 -> prediction_out=0.
- Four taken updates at pc=4, upd_ghr=0000 -> counter[0][1] saturates at 11; one not-taken -> 10, prediction still 1; three more not-taken -> saturates at 00.
- pred_valid and mispredict update (upd_ghr=1010, upd_taken=1) same cycle -> ghr_out=0101, lookup shift dropped.
- enable=0 with pred_valid and upd_valid asserted -> GHR and all counters unchanged, prediction_out still driven.
- Build with BP_GSHARE_EN, GHR=0011, pc=0xC -> lookup reads row 0000 column 11; without macro reads row 0011 column 11.
